// File: rtl/conv3x3_stream_if.sv
// Pixel-in / result-out stream bundle for conv3x3_stream.
// master = upstream source and downstream sink; slave = the convolver.
interface conv3x3_stream_if #(
  parameter int PIX_W = 1,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster pixel stream with two line buffers,
// a single output holding stage, optional saturation and binary threshold.
module conv3x3_stream #(
  parameter int IMG_W = 10,
  parameter int IMG_H = 10,
  parameter int PIX_W = 1,
  parameter int ACC_W = 16,
  parameter int SAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  conv3x3_stream_if.slave   bus,
  input  logic [8:0][15:0]  mask,
  input  logic [15:0]       bias,
  input  logic              mode
);

  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FULL_W = PIX_W + 20;
  localparam int EXT_W  = (FULL_W > ACC_W) ? FULL_W : ACC_W;
  localparam logic signed [EXT_W-1:0] SMAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SMIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [PIX_W-1:0] r_lb_top [IMG_W];
  logic [PIX_W-1:0] r_lb_mid [IMG_W];
  logic [PIX_W-1:0] r_win    [9];
  logic [PIX_W-1:0] w_nwin   [9];

  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_data;
  logic              r_out_last;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_complete;
  logic              w_last_pix;
  logic signed [FULL_W-1:0] w_sum;
  logic signed [EXT_W-1:0]  w_ext;
  logic [ACC_W-1:0]  w_res;

  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_complete = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_last_pix = (r_row == RW'(IMG_H-1)) && (r_col == CW'(IMG_W-1));

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

  // Window as it will be after this pixel shifts in; the result is taken from
  // it so the completing pixel's own column contributes in the same cycle.
  always_comb begin
    w_nwin[0] = r_win[1];
    w_nwin[1] = r_win[2];
    w_nwin[2] = r_lb_top[r_col];
    w_nwin[3] = r_win[4];
    w_nwin[4] = r_win[5];
    w_nwin[5] = r_lb_mid[r_col];
    w_nwin[6] = r_win[7];
    w_nwin[7] = r_win[8];
    w_nwin[8] = bus.in_pixel;
  end

  always_comb begin
    w_sum = -(FULL_W'($signed(bias)));
    for (int unsigned k = 0; k < 9; k++) begin
      w_sum = w_sum + FULL_W'($signed(mask[k])) * FULL_W'($signed({1'b0, w_nwin[k]}));
    end
    w_ext = EXT_W'(w_sum);
    w_res = w_ext[ACC_W-1:0];
    if (SAT != 0) begin
      if (w_ext > SMAX)      w_res = SMAX[ACC_W-1:0];
      else if (w_ext < SMIN) w_res = SMIN[ACC_W-1:0];
    end
    if (mode) w_res = (w_sum > 0) ? ACC_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      for (int unsigned k = 0; k < 9; k++) r_win[k] <= '0;
    end else begin
      if (w_accept) begin
        r_win <= w_nwin;
        if (r_col == CW'(IMG_W-1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_H-1)) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_complete) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_last  <= w_last_pix;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Line buffers carry no reset; rows 0-1 never produce results.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb_top[r_col] <= r_lb_mid[r_col];
      r_lb_mid[r_col] <= bus.in_pixel;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 4x4 image: saturating and wrapping
// builds run side by side on the same stream.
module tb_conv3x3_stream;

  logic             clk;
  logic             rst_n;
  logic [8:0][15:0] t_mask;
  logic [15:0]      t_bias;
  logic             t_mode;

  conv3x3_stream_if #(.PIX_W(8), .ACC_W(16)) bus  ();
  conv3x3_stream_if #(.PIX_W(8), .ACC_W(16)) bus0 ();

  conv3x3_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ACC_W(16), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mask(t_mask), .bias(t_bias), .mode(t_mode)
  );

  conv3x3_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ACC_W(16), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .mask(t_mask), .bias(t_bias), .mode(t_mode)
  );

  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_pixel  = bus.in_pixel;
  assign bus0.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q_d  [$];
  logic        q_l  [$];
  logic [15:0] q_d0 [$];

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q_d.push_back(bus.out_data);
      q_l.push_back(bus.out_last);
      q_d0.push_back(bus0.out_data);
    end
  end

  typedef struct packed {
    logic [8:0][15:0] mask;
    logic [15:0]      bias;
    logic             mode;
    logic             kind;   // 0: ramp 1..16, 1: all 255
    logic [3:0][15:0] exp;
    logic [3:0][15:0] exp0;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_q();
    q_d.delete();
    q_l.delete();
    q_d0.delete();
  endtask

  task automatic send_pixel(input logic [7:0] p);
    int unsigned n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = p;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frames(input logic kind, input int nframes);
    for (int f = 0; f < nframes; f++)
      for (int i = 0; i < 16; i++)
        send_pixel(kind ? 8'd255 : 8'(i + 1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string nm, input logic [3:0][15:0] e, input logic [3:0][15:0] e0);
    logic [15:0] d, d0;
    logic l;
    if (q_d.size() < 4) begin
      check({nm, "_count"}, q_d.size(), 4);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      d  = q_d.pop_front();
      l  = q_l.pop_front();
      d0 = q_d0.pop_front();
      check($sformatf("%s_data%0d", nm, k), int'($signed(d)), int'($signed(e[k])));
      check($sformatf("%s_last%0d", nm, k), int'(l), (k == 3) ? 1 : 0);
      check($sformatf("%s_wrap%0d", nm, k), int'($signed(d0)), int'($signed(e0[k])));
    end
  endtask

  task automatic set_ones(input logic [15:0] b, input logic m);
    t_mask = {9{16'd1}};
    t_bias = b;
    t_mode = m;
  endtask

  localparam logic [3:0][15:0] E_RAMP = {16'd99, 16'd90, 16'd63, 16'd54};

  initial begin
    // Expected values are listed oldest result in element [0].
    vecs[0] = '0; vecs[0].mask = {9{16'd1}}; vecs[0].kind = 1'b0;
    vecs[0].exp = E_RAMP; vecs[0].exp0 = E_RAMP;

    vecs[1] = '0; vecs[1].mask = {9{16'd1}}; vecs[1].bias = 16'd60; vecs[1].mode = 1'b1;
    vecs[1].exp = {16'd1, 16'd1, 16'd1, 16'd0}; vecs[1].exp0 = {16'd1, 16'd1, 16'd1, 16'd0};

    vecs[2] = '0; vecs[2].mask[4] = 16'd1000; vecs[2].kind = 1'b1;
    vecs[2].exp = {4{16'h7FFF}}; vecs[2].exp0 = {4{16'hE418}};

    vecs[3] = '0; vecs[3].mask[4] = 16'hFC18; vecs[3].kind = 1'b1;
    vecs[3].exp = {4{16'h8000}}; vecs[3].exp0 = {4{16'h1BE8}};

    vecs[4] = '0;
    vecs[4].mask[0] = 16'hFFFF; vecs[4].mask[1] = 16'hFFFF; vecs[4].mask[2] = 16'hFFFF;
    vecs[4].mask[6] = 16'd1;    vecs[4].mask[7] = 16'd1;    vecs[4].mask[8] = 16'd1;
    vecs[4].bias = 16'hFFFA;
    vecs[4].exp = {4{16'd30}}; vecs[4].exp0 = {4{16'd30}};

    vecs[5] = '0; vecs[5].mask[0] = 16'd1; vecs[5].mask[8] = 16'd100;
    vecs[5].exp = {16'd1606, 16'd1505, 16'd1202, 16'd1101};
    vecs[5].exp0 = {16'd1606, 16'd1505, 16'd1202, 16'd1101};

    vecs[6] = '0; vecs[6].mask = {9{16'd1}}; vecs[6].bias = 16'd54; vecs[6].mode = 1'b1;
    vecs[6].exp = {16'd1, 16'd1, 16'd1, 16'd0}; vecs[6].exp0 = {16'd1, 16'd1, 16'd1, 16'd0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.out_ready = 1'b1;
    set_ones(16'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data",  int'(bus.out_data), 0);
    check("rst_out_last",  int'(bus.out_last), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      t_mask = vecs[v].mask;
      t_bias = vecs[v].bias;
      t_mode = vecs[v].mode;
      clear_q();
      send_frames(vecs[v].kind, 1);
      drain();
      check($sformatf("vec%0d_count", v), q_d.size(), 4);
      check_frame($sformatf("vec%0d", v), vecs[v].exp, vecs[v].exp0);
    end

    // Backpressure while the first result (54) is held.
    set_ones(16'd0, 1'b0);
    clear_q();
    for (int i = 1; i <= 10; i++) send_pixel(8'(i));
    bus.out_ready = 1'b0;
    send_pixel(8'd11);
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'd12;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready%0d", c), int'(bus.in_ready), 0);
      check($sformatf("bp_out_valid%0d", c), int'(bus.out_valid), 1);
      check($sformatf("bp_out_data%0d", c), int'(bus.out_data), 54);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 12; i <= 16; i++) send_pixel(8'(i));
    bus.in_valid = 1'b0;
    drain();
    check("bp_count", q_d.size(), 4);
    check_frame("bp", E_RAMP, E_RAMP);

    // Reset in the middle of a frame discards the partial frame.
    clear_q();
    for (int i = 1; i <= 7; i++) send_pixel(8'(i));
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_q();
    send_frames(1'b0, 1);
    drain();
    check("midrst_count", q_d.size(), 4);
    check_frame("midrst", E_RAMP, E_RAMP);

    // Two frames with in_valid held high throughout.
    clear_q();
    send_frames(1'b0, 2);
    drain();
    check("b2b_count", q_d.size(), 8);
    check_frame("b2b_f0", E_RAMP, E_RAMP);
    check_frame("b2b_f1", E_RAMP, E_RAMP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
